// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the pipeline and latch controls back to it.
// Optional perf counter ports exist only when PIPE_HAZARD_CTRL_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs, id_rt, ex_wn;
  logic id_use_rs, id_use_rt, ex_wreg, ex_m2reg, id_redirect;
  logic mem_wmem, mem_m2reg, dmem_ready, dmem_req;
  logic en_pc, en_ifid, flush_ifid, en_idex, en_exmem, en_memwb, freeze, mem_err;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_flush;
`endif
  modport master (
    output id_rs, id_rt, ex_wn, id_use_rs, id_use_rt, ex_wreg, ex_m2reg, id_redirect,
    output mem_wmem, mem_m2reg, dmem_ready,
    input dmem_req, en_pc, en_ifid, flush_ifid, en_idex, en_exmem, en_memwb, freeze, mem_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , input perf_stall, perf_flush
`endif
  );
  modport slave (
    input id_rs, id_rt, ex_wn, id_use_rs, id_use_rt, ex_wreg, ex_m2reg, id_redirect,
    input mem_wmem, mem_m2reg, dmem_ready,
    output dmem_req, en_pc, en_ifid, flush_ifid, en_idex, en_exmem, en_memwb, freeze, mem_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , output perf_stall, perf_flush
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, redirect flush and data-memory wait sequencing.
// Define PIPE_HAZARD_CTRL_PERF_EN to add perf_stall/perf_flush counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic clrn,
  pipe_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic err_q, err_nx, mem_acc, lu, hold, req, stall, flush;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state <= RUN;
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      err_q <= err_nx;
    end
  always_comb begin
    mem_acc = hz.mem_wmem | hz.mem_m2reg;
    lu = hz.ex_m2reg & hz.ex_wreg & (hz.ex_wn != 5'd0) &
         ((hz.id_use_rs & (hz.id_rs == hz.ex_wn)) | (hz.id_use_rt & (hz.id_rt == hz.ex_wn)));
    state_nx = state;
    cnt_nx = cnt;
    err_nx = err_q;
    hold = 1'b0;
    req = 1'b0;
    case (state)
      RUN: begin
        req = mem_acc;
        if (mem_acc && !hz.dmem_ready) begin
          hold = 1'b1;
          state_nx = WAIT;
          cnt_nx = CNT_W'(1);
        end
      end
      WAIT: begin
        req = 1'b1;
        if (hz.dmem_ready) begin
          state_nx = RUN;
          cnt_nx = '0;
        end else begin
          hold = 1'b1;
          if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_nx = ERR;
            err_nx = 1'b1;
          end else cnt_nx = cnt + CNT_W'(1);
        end
      end
      ERR: hold = 1'b1;
      default: begin
        hold = 1'b1;
        state_nx = RUN;
      end
    endcase
    // A load-use stall wins over a redirect: branch operands are not valid yet.
    stall = !hold & lu;
    flush = !hold & !lu & hz.id_redirect;
  end
  assign hz.dmem_req = req;
  assign hz.freeze = hold;
  assign hz.en_pc = !stall;
  assign hz.en_ifid = !stall;
  assign hz.en_idex = !stall;
  assign hz.en_exmem = 1'b1;
  assign hz.en_memwb = 1'b1;
  assign hz.flush_ifid = flush;
  assign hz.mem_err = err_q;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_q + {31'd0, hold | stall};
      perf_flush_q <= perf_flush_q + {31'd0, flush};
    end
  assign hz.perf_stall = perf_stall_q;
  assign hz.perf_flush = perf_flush_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors feed a scoreboard queue; a negedge monitor checks outputs.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  int compared = 0;
  int mismatched = 0;
  typedef struct {
    logic [8:0] v;
    string n;
  } exp_t;
  exp_t sb[$];
  // order: {dmem_req, en_pc, en_ifid, flush_ifid, en_idex, en_exmem, en_memwb, freeze, mem_err}
  localparam logic [8:0] NORM = 9'b0_11_0_111_0_0;
  localparam logic [8:0] LUS  = 9'b0_00_0_011_0_0;
  localparam logic [8:0] FLS  = 9'b0_11_1_111_0_0;
  localparam logic [8:0] FRZ  = 9'b1_11_0_111_1_0;
  localparam logic [8:0] MACC = 9'b1_11_0_111_0_0;
  localparam logic [8:0] MFLS = 9'b1_11_1_111_0_0;
  localparam logic [8:0] ERRV = 9'b0_11_0_111_1_1;

  pipe_hazard_ctrl_if hz ();
  pipe_hazard_ctrl #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (.clk(clk), .clrn(clrn), .hz(hz));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [8:0] act;
      e = sb.pop_front();
      act = {hz.dmem_req, hz.en_pc, hz.en_ifid, hz.flush_ifid, hz.en_idex,
             hz.en_exmem, hz.en_memwb, hz.freeze, hz.mem_err};
      compared++;
      if (act !== e.v) begin
        mismatched++;
        $display("FAIL %s: got %b expected %b", e.n, act, e.v);
      end
    end
  end

  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic ut,
                     input logic w, input logic l, input logic [4:0] wn, input logic rd,
                     input logic sw, input logic ld, input logic rdy, input logic [8:0] exp_v,
                     input string nm);
    hz.id_rs = rs; hz.id_rt = rt; hz.id_use_rs = ur; hz.id_use_rt = ut;
    hz.ex_wreg = w; hz.ex_m2reg = l; hz.ex_wn = wn; hz.id_redirect = rd;
    hz.mem_wmem = sw; hz.mem_m2reg = ld; hz.dmem_ready = rdy;
    sb.push_back('{exp_v, nm});
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "reset");
    clrn = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "idle");
    cyc(5, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0, LUS,  "lu_rs");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "lu_after");
    cyc(0, 7, 0, 1, 1, 1, 7, 0, 0, 0, 0, LUS,  "lu_rt");
    cyc(7, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, NORM, "lu_nouse");
    cyc(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, NORM, "lu_r0");
    cyc(5, 0, 1, 0, 1, 0, 5, 0, 0, 0, 0, NORM, "no_load");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FLS,  "redirect");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "redirect_end");
    cyc(5, 0, 1, 0, 1, 1, 5, 1, 0, 0, 0, LUS,  "redir_lu");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, MACC, "mem_zero_wait");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "wait0");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "wait1");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "wait2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, MACC, "wait_done");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, "ready_idle");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  "st_wait");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, MFLS, "wait_flush");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  "to_run");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  "to_w1");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  "to_w2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  "to_w3");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ERRV, "err0");
    cyc(5, 0, 1, 0, 1, 1, 5, 1, 1, 0, 1, ERRV, "err_sticky");
    clrn = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "reset_err");
    clrn = 1'b1;
    cyc(5, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0, LUS,  "p_lu0");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "p_idle");
    cyc(0, 9, 0, 1, 1, 1, 9, 0, 0, 0, 0, LUS,  "p_lu1");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FLS,  "p_flush");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "p_frz0");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "p_frz1");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  "p_frz2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, MACC, "p_done");
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    compared += 2;
    if (hz.perf_stall !== 32'd5) begin
      mismatched++;
      $display("FAIL perf_stall: got %0d expected 5", hz.perf_stall);
    end
    if (hz.perf_flush !== 32'd1) begin
      mismatched++;
      $display("FAIL perf_flush: got %0d expected 1", hz.perf_flush);
    end
`endif
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline; sits beside the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches and drives their enables.
- Detects load-use hazards, squashes the wrong-path fetch on taken branches/jumps, and sequences a variable-latency data-memory handshake for the instruction in MEM.
- Latch convention is fixed:
  - enable=0 on ID/EX, EX/MEM or MEM/WB inserts a bubble (wreg/wmem cleared).
  - The separate freeze output holds every pipeline register and the PC unchanged.

Parameters:
TIMEOUT_CYC, 64, max consecutive WAIT cycles before declaring a memory error (legal 2..255)
CNT_W, 8, width of the internal wait counter (must hold TIMEOUT_CYC)

Ports:
clk  input  1  system clock, rising edge
clrn  input  1  asynchronous active-low reset
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_use_rs  input  1  ID instruction reads rs
id_use_rt  input  1  ID instruction reads rt
ex_wreg  input  1  EX instruction writes a register
ex_m2reg  input  1  EX instruction is a load
ex_wn  input  5  EX destination register
id_redirect  input  1  ID resolved a taken branch/jump this cycle
mem_wmem  input  1  MEM instruction is a store (EX/MEM out_wmem)
mem_m2reg  input  1  MEM instruction is a load (EX/MEM out_m2reg)
dmem_ready  input  1  data memory completes current access this cycle
dmem_req  output  1  data memory access request
en_pc  output  1  PC update enable
en_ifid  output  1  IF/ID load enable
flush_ifid  output  1  clear IF/ID to NOP on next edge
en_idex  output  1  ID/EX enable (0 = bubble)
en_exmem  output  1  EX/MEM enable (0 = bubble)
en_memwb  output  1  MEM/WB enable (0 = bubble)
freeze  output  1  hold all pipeline registers and PC; overrides every en_*/flush
mem_err  output  1  sticky memory timeout flag

Behaviour:
- Reset (clrn=0, async):
  - state=RUN, wait counter=0, mem_err=0.
  - Outputs: en_*=1, flush_ifid=0, freeze=0, dmem_req=0.
- All outputs are combinational from state plus inputs; only state, counter and mem_err are registered.
- Definitions:
  - mem_acc = mem_wmem | mem_m2reg.
  - lu = ex_m2reg & ex_wreg & (ex_wn!=0) & ((id_use_rs & id_rs==ex_wn) | (id_use_rt & id_rt==ex_wn)).
- State RUN:
  - dmem_req = mem_acc.
  - If mem_acc & !dmem_ready: freeze=1 this cycle, next state WAIT, counter=1.
  - Otherwise freeze=0 and the hazard logic applies:
    - lu=1: en_pc=0, en_ifid=0, en_idex=0 (one bubble); en_exmem=1, en_memwb=1. id_redirect is ignored this cycle because branch operands are not yet valid.
    - lu=0 and id_redirect=1: flush_ifid=1, all en_*=1.
    - Otherwise: all en_*=1, flush_ifid=0.
  - Zero-wait access (dmem_ready=1 in the same cycle) costs no stall.
- State WAIT:
  - dmem_req=1, freeze=1.
  - If dmem_ready: freeze=0 this cycle, hazard logic applies as in RUN, next state RUN, counter=0.
  - Else if counter==TIMEOUT_CYC-1: next state ERR, mem_err=1.
  - Else counter+1.
  - dmem_ready while not requesting (RUN with mem_acc=0) is ignored.
- State ERR:
  - freeze=1, dmem_req=0, mem_err=1.
  - Exits only via reset.
- Priority: freeze > lu > id_redirect.
- Reset mid-WAIT abandons the access: dmem_req drops asynchronously, state=RUN.

Optional Feature:
- Macro PIPE_HAZARD_CTRL_PERF_EN.
- When defined, adds outputs:
  - perf_stall (32): counts cycles with freeze=1 or lu stall.
  - perf_flush (32): counts flush_ifid pulses.
- Both counters wrap at 2^32 and reset to 0 on clrn.
- When undefined, neither port nor logic exists.

Test Plan:
- Load-use: ex_m2reg=1, ex_wreg=1, ex_wn=5, id_rs=5, id_use_rs=1 -> one cycle en_pc=en_ifid=en_idex=0, en_exmem=1; next cycle (ex bubble) all en=1.
- ex_wn=0 with id_rs=0, otherwise same as load-use -> no stall.
- id_redirect=1, no lu -> flush_ifid=1 for exactly that cycle; with lu=1 in the same cycle -> flush_ifid=0 and stall.
- mem_m2reg=1, dmem_ready low 3 cycles, high on the 4th -> freeze=1 for 3 cycles, dmem_req=1 for 4 cycles, freeze=0 on the ready cycle.
- TIMEOUT_CYC=4, store with dmem_ready never asserted -> mem_err=1 after entering WAIT plus 3 cycles, freeze stays 1, dmem_req=0; assert clrn=0 -> all outputs return to reset values immediately.
- With PIPE_HAZARD_CTRL_PERF_EN: 2 lu stalls, 3 freeze cycles and 1 flush -> perf_stall=5, perf_flush=1.
